// File: rtl/packed_switch_seq.sv
// Frame sequencer for one packed_switch stage: walks a per-beat swap mask, handshakes the
// input stream and re-aligns valid/last with the switch output. Optional PACKED_SWITCH_SEQ_LASTCHK_EN.
module packed_switch_seq #(
   parameter int NUM_BEATS = 20,
   parameter int LATENCY   = 2
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 CFG_WE,
   input  logic [NUM_BEATS-1:0] CFG_MASK,
   input  logic                 START,
   output logic                 BUSY,
   output logic                 DONE,
   input  logic                 I_VALID,
   output logic                 I_READY,
   output logic                 SWITCH_SET,
   output logic                 O_VALID,
   output logic                 O_LAST,
   output logic                 ERR,
   input  logic                 I_LAST
);

   localparam int CW = (NUM_BEATS > 2) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEATS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

   state_e               state_q, state_d;
   logic [NUM_BEATS-1:0] mask_q, mask_d;
   logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
   logic [LATENCY-1:0]   vld_q, vld_d, lst_q, lst_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic                 accept, is_last;

   always_comb begin
      accept     = (state_q == S_RUN) && I_VALID;
      is_last    = (beat_cnt_q == LAST_BEAT);
      state_d    = state_q;
      mask_d     = mask_q;
      beat_cnt_d = beat_cnt_q;
      // Pipe depth equals the switch latency so the tail lines up with O_PORT.
      vld_d[0]   = accept;
      lst_d[0]   = accept && is_last;
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         lst_d[i] = lst_q[i-1];
      end
      case (state_q)
         S_IDLE: begin
            beat_cnt_d = '0;
            if (CFG_WE) mask_d = CFG_MASK;
            if (START) state_d = S_RUN;
         end
         S_RUN: begin
            if (accept) begin
               if (is_last) begin
                  beat_cnt_d = '0;
                  state_d    = S_DRAIN;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         S_DRAIN: if (vld_q == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      // Raised for the final DRAIN cycle, i.e. the one that moves back to IDLE.
      done_d = (state_d == S_DRAIN) && (vld_d == '0);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         mask_q     <= '0;
         beat_cnt_q <= '0;
         vld_q      <= '0;
         lst_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         beat_cnt_q <= beat_cnt_d;
         vld_q      <= vld_d;
         lst_q      <= lst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign I_READY    = (state_q == S_RUN);
   assign SWITCH_SET = I_READY ? mask_q[beat_cnt_q] : 1'b0;
   assign O_VALID    = vld_q[LATENCY-1];
   assign O_LAST     = lst_q[LATENCY-1];
   assign BUSY       = busy_q;
   assign DONE       = done_q;

`ifdef PACKED_SWITCH_SEQ_LASTCHK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q || (accept && (I_LAST != is_last));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign ERR = err_q;
`else
   logic unused_i_last;
   assign unused_i_last = I_LAST;
   assign ERR           = 1'b0;
`endif

endmodule

// File: tb/tb_packed_switch_seq.sv
// Randomized bench for packed_switch_seq: a cycle-indexed frame model predicts every output.
module tb_packed_switch_seq;
   localparam int N   = 20;
   localparam int LAT = 2;

   logic         CLK = 1'b0, RST_N = 1'b0, CFG_WE = 1'b0, START = 1'b0;
   logic         I_VALID = 1'b0, I_LAST = 1'b0;
   logic [N-1:0] CFG_MASK = '0;
   logic         BUSY, DONE, I_READY, SWITCH_SET, O_VALID, O_LAST, ERR;

   int           tests = 0, fails = 0;
   logic [N-1:0] mdl_mask = '0;
   logic         err_exp = 1'b0;

   packed_switch_seq #(.NUM_BEATS(N), .LATENCY(LAT)) dut (
      .CLK(CLK), .RST_N(RST_N), .CFG_WE(CFG_WE), .CFG_MASK(CFG_MASK), .START(START),
      .BUSY(BUSY), .DONE(DONE), .I_VALID(I_VALID), .I_READY(I_READY),
      .SWITCH_SET(SWITCH_SET), .O_VALID(O_VALID), .O_LAST(O_LAST), .ERR(ERR), .I_LAST(I_LAST));

   always #5 CLK = ~CLK;

   // Runs one frame; expectations come from accept timestamps: output = accept LAT cycles ago.
   task automatic run_frame(input logic load, input logic [N-1:0] mask_in, input int mode,
                            input bit poke, input int abort_at, input int bad_beat,
                            output int last_k);
      bit   acc_hist [0:511];
      int   acc    = 0;
      int   done_k = -1;
      bit   run;
      logic e_rdy, e_set, e_ov, e_ol, e_done, e_busy;
      last_k = -1;
      for (int k = 0; k < 400; k++) begin
         @(negedge CLK);
         run    = (k >= 1) && (acc < N);
         e_rdy  = run;
         e_set  = run ? mdl_mask[acc] : 1'b0;
         e_ov   = (k >= LAT) && acc_hist[k-LAT];
         e_ol   = e_ov && (k - LAT == last_k);
         e_done = (k == done_k);
         e_busy = (k >= 1) && (done_k < 0 || k <= done_k);
         tests += 7;
         if (I_READY !== e_rdy)     begin fails++; $display("FAIL i_ready k=%0d got %b exp %b", k, I_READY, e_rdy); end
         if (SWITCH_SET !== e_set)  begin fails++; $display("FAIL switch_set k=%0d got %b exp %b", k, SWITCH_SET, e_set); end
         if (O_VALID !== e_ov)      begin fails++; $display("FAIL o_valid k=%0d got %b exp %b", k, O_VALID, e_ov); end
         if (O_LAST !== e_ol)       begin fails++; $display("FAIL o_last k=%0d got %b exp %b", k, O_LAST, e_ol); end
         if (DONE !== e_done)       begin fails++; $display("FAIL done k=%0d got %b exp %b", k, DONE, e_done); end
         if (BUSY !== e_busy)       begin fails++; $display("FAIL busy k=%0d got %b exp %b", k, BUSY, e_busy); end
         if (ERR !== err_exp)       begin fails++; $display("FAIL err k=%0d got %b exp %b", k, ERR, err_exp); end
         if (k == done_k) begin
            START = 1'b0; CFG_WE = 1'b0; I_VALID = 1'b0; I_LAST = 1'b0;
            return;
         end
         if (k == 0) begin
            START = 1'b1; CFG_WE = load; CFG_MASK = mask_in;
            if (load) mdl_mask = mask_in;
         end else begin
            START = poke; CFG_WE = poke; CFG_MASK = poke ? '1 : N'($urandom);
         end
         case (mode)
            0:       I_VALID = 1'b1;
            1:       I_VALID = (k % 2 == 0);
            default: I_VALID = 1'($urandom % 2);
         endcase
         I_LAST = (bad_beat >= 0) ? (acc == bad_beat) : (acc == N - 1);
         if (run && I_VALID) begin
            acc_hist[k] = 1'b1;
`ifdef PACKED_SWITCH_SEQ_LASTCHK_EN
            if (I_LAST != (acc == N - 1)) err_exp = 1'b1;
`endif
            if (acc == N - 1) begin
               last_k = k;
               done_k = k + LAT + 1;
            end
            acc++;
         end
         if (abort_at >= 0 && acc == abort_at) return;
      end
      tests++; fails++;
      $display("FAIL frame_timeout got no DONE exp DONE within 400 cycles");
   endtask

   task automatic test_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      tests++;
      if ({BUSY, DONE, I_READY, SWITCH_SET, O_VALID, O_LAST, ERR} !== 7'b0) begin
         fails++;
         $display("FAIL reset_outputs got %b exp 0000000",
                  {BUSY, DONE, I_READY, SWITCH_SET, O_VALID, O_LAST, ERR});
      end
      RST_N = 1'b1;
   endtask

   task automatic test_single_swap();
      int lk;
      @(negedge CLK); CFG_WE = 1'b1; CFG_MASK = 20'h0_0001; mdl_mask = 20'h0_0001;
      @(negedge CLK); CFG_WE = 1'b0;
      run_frame(1'b0, '0, 0, 1'b0, -1, -1, lk);
      tests++;
      if (lk !== 20) begin fails++; $display("FAIL single_swap_last_accept got %0d exp 20", lk); end
   endtask

   task automatic test_alt_gaps();
      int lk;
      run_frame(1'b1, 20'hA_AAAA, 1, 1'b0, -1, -1, lk);
      tests++;
      if (lk !== 40) begin fails++; $display("FAIL alt_gaps_last_accept got %0d exp 40", lk); end
   endtask

   task automatic test_cfg_ignored();
      int lk;
      run_frame(1'b1, 20'h3_0C05, 2, 1'b1, -1, -1, lk);
      run_frame(1'b1, 20'hF_FFFF, 2, 1'b0, -1, -1, lk);
   endtask

   task automatic test_random();
      int lk;
      for (int i = 0; i < 4; i++)
         run_frame(1'b1, N'($urandom), 2, 1'b0, -1, -1, lk);
   endtask

   task automatic test_reset_abort();
      int lk;
      run_frame(1'b1, 20'hF_0F0F, 0, 1'b0, 8, -1, lk);
      @(posedge CLK); #2;
      RST_N = 1'b0; #1;
      tests++;
      if ({BUSY, DONE, I_READY, SWITCH_SET, O_VALID, O_LAST, ERR} !== 7'b0) begin
         fails++;
         $display("FAIL abort_async_reset got %b exp 0000000",
                  {BUSY, DONE, I_READY, SWITCH_SET, O_VALID, O_LAST, ERR});
      end
      I_VALID = 1'b0; mdl_mask = '0; err_exp = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         tests++;
         if (DONE !== 1'b0) begin fails++; $display("FAIL abort_no_done got %b exp 0", DONE); end
      end
      RST_N = 1'b1;
      run_frame(1'b0, '0, 0, 1'b0, -1, -1, lk);
      tests++;
      if (lk !== 20) begin fails++; $display("FAIL post_abort_last_accept got %0d exp 20", lk); end
   endtask

   task automatic test_lastchk();
      int lk;
      run_frame(1'b1, N'($urandom), 0, 1'b0, -1, 18, lk);
      repeat (2) @(negedge CLK);
      tests++;
`ifdef PACKED_SWITCH_SEQ_LASTCHK_EN
      if (ERR !== 1'b1) begin fails++; $display("FAIL lastchk_sticky got %b exp 1", ERR); end
`else
      if (ERR !== 1'b0) begin fails++; $display("FAIL lastchk_disabled got %b exp 0", ERR); end
`endif
   endtask

   initial begin
      test_reset();
      test_single_swap();
      test_alt_gaps();
      test_cfg_ignored();
      test_random();
      test_reset_abort();
      test_lastchk();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
